// File: rtl/synth_pkg.sv
// Shared synth definitions: mode encoding, default pitch width, note periods.
package synth_pkg;

    typedef enum logic {
        PLAY = 1'b0,
        DEMO = 1'b1
    } mode_t;

    localparam int PITCH_W_DEFAULT = 12;

    // Period counts; a larger count is a lower note.
    localparam logic [11:0] NOTE_C4 = 12'd357;
    localparam logic [11:0] NOTE_D4 = 12'd318;
    localparam logic [11:0] NOTE_E4 = 12'd283;
    localparam logic [11:0] NOTE_F4 = 12'd267;
    localparam logic [11:0] NOTE_G4 = 12'd238;
    localparam logic [11:0] NOTE_A4 = 12'd212;
    localparam logic [11:0] NOTE_B4 = 12'd189;
    localparam logic [11:0] NOTE_C5 = 12'd178;
    localparam logic [11:0] NOTE_A5 = 12'd106;

endpackage

// File: rtl/voice_picker.sv
// Chooses the channel for the next allocation: lowest idle channel first,
// otherwise the oldest busy channel (ties resolved to the lowest index).
module voice_picker #(
    parameter int NUM_CHANNELS = 4,
    parameter int AGE_W        = 2,
    parameter int IDX_W        = 2
) (
    input  logic [NUM_CHANNELS-1:0]       busy,
    input  logic [NUM_CHANNELS*AGE_W-1:0] age,
    output logic [IDX_W-1:0]              target,
    output logic                          full
);

    logic [IDX_W-1:0] free_idx;
    logic [IDX_W-1:0] old_idx;
    logic [AGE_W-1:0] old_age;

    // Lowest-index idle channel (scan downward so the lowest match wins).
    always_comb begin
        free_idx = '0;
        for (int c = NUM_CHANNELS - 1; c >= 0; c--) begin
            if (!busy[c]) free_idx = IDX_W'(c);
        end
    end

    // Oldest channel; strict compare keeps the lowest index on equal ages.
    always_comb begin
        old_idx = '0;
        old_age = age[AGE_W-1:0];
        for (int c = 1; c < NUM_CHANNELS; c++) begin
            if (age[c*AGE_W +: AGE_W] > old_age) begin
                old_age = age[c*AGE_W +: AGE_W];
                old_idx = IDX_W'(c);
            end
        end
    end

    assign full   = &busy;
    assign target = full ? old_idx : free_idx;

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic key-to-channel allocator with PLAY/DEMO mode and output mux.
module voice_allocator
    import synth_pkg::*;
#(
    parameter int NUM_KEYS     = 8,
    parameter int NUM_CHANNELS = 4,
    parameter int PITCH_W      = PITCH_W_DEFAULT,
    parameter logic [NUM_KEYS*PITCH_W-1:0] PITCH_TABLE =
        {NOTE_C5, NOTE_B4, NOTE_A4, NOTE_G4, NOTE_F4, NOTE_E4, NOTE_D4, NOTE_C4}
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_KEYS-1:0]               keys,
    input  logic [1:0]                        waveform,
    input  logic                              demo_req,
    input  logic [NUM_CHANNELS-1:0]           demo_channel_ena,
    input  logic [NUM_CHANNELS*PITCH_W-1:0]   demo_pitches,
    input  logic [NUM_CHANNELS*2-1:0]         demo_waveforms,
    output logic [NUM_CHANNELS-1:0]           channel_ena,
    output logic [NUM_CHANNELS*PITCH_W-1:0]   pitches,
    output logic [NUM_CHANNELS*2-1:0]         waveforms,
    output logic                              demo_ena,
    output logic [$clog2(NUM_CHANNELS+1)-1:0] active_count
);

    localparam int KW  = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
    localparam int CW  = $clog2(NUM_CHANNELS);
    localparam int AW  = CW;
    localparam int ACW = $clog2(NUM_CHANNELS + 1);
    localparam logic [AW-1:0] AGE_MAX = AW'(NUM_CHANNELS - 1);

    mode_t state_reg, state_next;

    logic [NUM_KEYS-1:0] prev_reg, pending_reg, pending_next, eligible;
    logic [NUM_CHANNELS-1:0] busy_reg, busy_next, release_mask, busy_rel;
    logic [KW-1:0]      key_idx_reg [NUM_CHANNELS];
    logic [KW-1:0]      key_idx_next[NUM_CHANNELS];
    logic [AW-1:0]      age_reg     [NUM_CHANNELS];
    logic [AW-1:0]      age_next    [NUM_CHANNELS];
    logic [PITCH_W-1:0] pitch_reg   [NUM_CHANNELS];
    logic [PITCH_W-1:0] pitch_next  [NUM_CHANNELS];
    logic [1:0]         wave_reg    [NUM_CHANNELS];
    logic [1:0]         wave_next   [NUM_CHANNELS];

    logic [NUM_CHANNELS*AW-1:0] age_flat;
    logic [CW-1:0]              target;
    logic                       full;
    logic [KW-1:0]              serve_idx;
    logic                       serve_valid;

    logic [NUM_CHANNELS-1:0]         ena_out;
    logic [NUM_CHANNELS*PITCH_W-1:0] pitches_out;
    logic [NUM_CHANNELS*2-1:0]       waves_out;
    logic [ACW-1:0]                  count_out;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_age_flat
            assign age_flat[gi*AW +: AW] = age_reg[gi];
        end
    endgenerate

    voice_picker #(
        .NUM_CHANNELS (NUM_CHANNELS),
        .AGE_W        (AW),
        .IDX_W        (CW)
    ) u_picker (
        .busy   (busy_rel),
        .age    (age_flat),
        .target (target),
        .full   (full)
    );

    // Mode state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_reg <= PLAY;
        else      state_reg <= state_next;
    end

    // Mode transitions; a held demo button beats any key press.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            PLAY:    if (demo_req)                state_next = DEMO;
            DEMO:    if ((|keys) && !demo_req)    state_next = PLAY;
            default:                              state_next = PLAY;
        endcase
    end

    // Release detection (registered level) and lowest pending key selection.
    always_comb begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            release_mask[c] = busy_reg[c] & ~prev_reg[key_idx_reg[c]];
        end
        busy_rel    = busy_reg & ~release_mask;
        eligible    = pending_reg & prev_reg;
        serve_idx   = '0;
        serve_valid = |eligible;
        for (int k = NUM_KEYS - 1; k >= 0; k--) begin
            if (eligible[k]) serve_idx = KW'(k);
        end
    end

    // Next channel state: free released voices, allocate one key, age the rest.
    always_comb begin
        busy_next    = busy_rel;
        pending_next = eligible;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            key_idx_next[c] = key_idx_reg[c];
            age_next[c]     = release_mask[c] ? '0 : age_reg[c];
            pitch_next[c]   = pitch_reg[c];
            wave_next[c]    = wave_reg[c];
        end
        if (state_reg == DEMO) begin
            busy_next    = '0;
            pending_next = '0;
            for (int c = 0; c < NUM_CHANNELS; c++) age_next[c] = '0;
        end else begin
            if (serve_valid) begin
                pending_next[serve_idx] = 1'b0;
                for (int c = 0; c < NUM_CHANNELS; c++) begin
                    // Target is either an idle channel or a deliberate steal.
                    if ((CW'(c) == target) && (full || !busy_rel[c])) begin
                        busy_next[c]    = 1'b1;
                        key_idx_next[c] = serve_idx;
                        age_next[c]     = '0;
                        pitch_next[c]   = PITCH_TABLE[serve_idx*PITCH_W +: PITCH_W];
                        wave_next[c]    = waveform;
                    end else if (busy_rel[c] && (age_reg[c] != AGE_MAX)) begin
                        age_next[c] = age_reg[c] + 1'b1;
                    end
                end
            end
            pending_next = pending_next | (keys & ~prev_reg);
        end
    end

    // Output mux: demo passthrough in DEMO, channel registers in PLAY.
    always_comb begin
        ena_out     = '0;
        pitches_out = '0;
        waves_out   = '0;
        count_out   = '0;
        if (state_reg == DEMO) begin
            ena_out     = demo_channel_ena;
            pitches_out = demo_pitches;
            waves_out   = demo_waveforms;
        end else begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                ena_out[c] = busy_next[c];
                if (busy_next[c]) begin
                    pitches_out[c*PITCH_W +: PITCH_W] = pitch_next[c];
                    waves_out[c*2 +: 2]               = wave_next[c];
                end
                count_out = count_out + ACW'(busy_next[c]);
            end
        end
    end

    // Key history, pending flags and per-channel voice registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_reg    <= '0;
            pending_reg <= '0;
            busy_reg    <= '0;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                key_idx_reg[c] <= '0;
                age_reg[c]     <= '0;
                pitch_reg[c]   <= '0;
                wave_reg[c]    <= '0;
            end
        end else begin
            prev_reg    <= keys;
            pending_reg <= pending_next;
            busy_reg    <= busy_next;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                key_idx_reg[c] <= key_idx_next[c];
                age_reg[c]     <= age_next[c];
                pitch_reg[c]   <= pitch_next[c];
                wave_reg[c]    <= wave_next[c];
            end
        end
    end

    // Registered outputs to the mixer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            channel_ena  <= '0;
            pitches      <= '0;
            waveforms    <= '0;
            demo_ena     <= 1'b0;
            active_count <= '0;
        end else begin
            channel_ena  <= ena_out;
            pitches      <= pitches_out;
            waveforms    <= waves_out;
            demo_ena     <= (state_reg == DEMO);
            active_count <= count_out;
        end
    end

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator with hand-computed expectations.
module tb_voice_allocator;

    logic        clk;
    logic        rst;
    logic [7:0]  keys;
    logic [1:0]  waveform;
    logic        demo_req;
    logic [3:0]  demo_channel_ena;
    logic [47:0] demo_pitches;
    logic [7:0]  demo_waveforms;
    logic [3:0]  channel_ena;
    logic [47:0] pitches;
    logic [7:0]  waveforms;
    logic        demo_ena;
    logic [2:0]  active_count;

    int checks = 0;
    int errors = 0;

    voice_allocator dut (
        .clk              (clk),
        .rst              (rst),
        .keys             (keys),
        .waveform         (waveform),
        .demo_req         (demo_req),
        .demo_channel_ena (demo_channel_ena),
        .demo_pitches     (demo_pitches),
        .demo_waveforms   (demo_waveforms),
        .channel_ena      (channel_ena),
        .pitches          (pitches),
        .waveforms        (waveforms),
        .demo_ena         (demo_ena),
        .active_count     (active_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        rst              = 1'b0;
        keys             = 8'h00;
        waveform         = 2'd0;
        demo_req         = 1'b0;
        demo_channel_ena = 4'h0;
        demo_pitches     = 48'h0;
        demo_waveforms   = 8'h00;
        tick(); tick();
        chk("rst_ena",   channel_ena,  4'h0);
        chk("rst_pitch", pitches,      48'h0);
        chk("rst_wave",  waveforms,    8'h00);
        chk("rst_demo",  demo_ena,     1'b0);
        chk("rst_count", active_count, 3'd0);
        #2 rst = 1'b1;
        tick();

        // Single key 5 -> ch0, pitch 212, two edges of latency.
        keys = 8'h20; tick();
        chk("k5_lat", channel_ena, 4'h0);
        tick();
        chk("k5_ena",   channel_ena,    4'h1);
        chk("k5_pitch", pitches[11:0],  12'd212);
        chk("k5_count", active_count,   3'd1);
        keys = 8'h00; tick();
        chk("k5_hold", channel_ena, 4'h1);
        tick();
        chk("k5_rel", channel_ena, 4'h0);

        // Keys 0,2,3 together -> one allocation per cycle.
        keys = 8'h0D; tick(); tick();
        chk("k023_a", channel_ena, 4'h1);
        tick();
        chk("k023_b", channel_ena, 4'h3);
        tick();
        chk("k023_c",   channel_ena,  4'h7);
        chk("k023_pit", pitches,      {12'd0, 12'd267, 12'd283, 12'd357});
        chk("k023_cnt", active_count, 3'd3);
        keys = 8'h00; tick(); tick();
        chk("k023_rel", channel_ena, 4'h0);
        chk("k023_cnt0", active_count, 3'd0);

        // Four voices held, key 4 steals the oldest (ch0).
        keys = 8'h0F; tick(); tick(); tick(); tick(); tick();
        chk("full_ena", channel_ena, 4'hF);
        chk("full_pit", pitches, {12'd267, 12'd283, 12'd318, 12'd357});
        keys = 8'h1F; tick(); tick();
        chk("steal_pit", pitches, {12'd267, 12'd283, 12'd318, 12'd238});
        chk("steal_cnt", active_count, 3'd4);
        keys = 8'h1E; tick(); tick();
        chk("stolen_rel", channel_ena, 4'hF);
        chk("stolen_cnt", active_count, 3'd4);
        keys = 8'h00; tick(); tick();
        chk("all_rel", channel_ena, 4'h0);

        // Waveform latched at allocation.
        waveform = 2'd2; keys = 8'h02; tick(); tick();
        waveform = 2'd3; keys = 8'h42; tick(); tick();
        chk("wave_lat", waveforms, 8'h0E);
        chk("wave_pit", pitches, {12'd0, 12'd0, 12'd189, 12'd318});

        // DEMO entry with voices held.
        demo_req         = 1'b1;
        demo_channel_ena = 4'hA;
        demo_pitches     = 48'h123456789ABC;
        demo_waveforms   = 8'h5A;
        tick();
        chk("demo_lat", demo_ena, 1'b0);
        chk("demo_lat_ena", channel_ena, 4'h3);
        tick();
        chk("demo_ena",   demo_ena,     1'b1);
        chk("demo_pass",  channel_ena,  4'hA);
        chk("demo_pitch", pitches,      48'h123456789ABC);
        chk("demo_wave",  waveforms,    8'h5A);
        chk("demo_count", active_count, 3'd0);
        demo_channel_ena = 4'h5; keys = 8'hC2; tick();
        chk("demo_upd", channel_ena, 4'h5);
        tick();
        chk("demo_wins", demo_ena, 1'b1);
        demo_req = 1'b0; tick();
        chk("play_lat", demo_ena, 1'b1);
        tick();
        chk("play_back", demo_ena,    1'b0);
        chk("play_ena",  channel_ena, 4'h0);
        tick();
        chk("play_held", channel_ena, 4'h0);
        chk("play_cnt",  active_count, 3'd0);
        keys = 8'h00; tick(); tick();

        // Asynchronous reset mid-allocation, keys held through it.
        keys = 8'h07; tick(); tick();
        chk("prerst_ena", channel_ena, 4'h1);
        rst = 1'b0; #1;
        chk("arst_ena",   channel_ena,  4'h0);
        chk("arst_pitch", pitches,      48'h0);
        chk("arst_count", active_count, 3'd0);
        #2 rst = 1'b1;
        tick();
        chk("post_a", channel_ena, 4'h0);
        tick();
        chk("post_b", channel_ena, 4'h1);
        tick();
        chk("post_c", channel_ena, 4'h3);
        tick();
        chk("post_d",   channel_ena, 4'h7);
        chk("post_pit", pitches, {12'd0, 12'd283, 12'd318, 12'd357});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
